data_memory_sized: RTL and testbench

Parametrised, byte-addressable data memory for the MEM stage of the 32-bit pipelined RV32I core. Supports byte, halfword and word loads and stores, with sign or zero extension selected by funct3. A load or store that crosses a word boundary is executed as a two-cycle split access while the pipeline is stalled. Sits in place of the basic word memory, between the EX/MEM and MEM/WB registers.

---
 rtl/dmem_pkg.sv | 60 ++++++
 rtl/data_memory_sized_if.sv | 23 ++
 rtl/dmem_lane_fmt.sv | 65 ++++++
 rtl/data_memory_sized.sv | 135 +++++++++++++
 tb/tb_data_memory_sized.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the sized data memory: funct3 encodings, access
// size and split-FSM state types, the store formatting payload and small
// decode helpers.
package dmem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } state_e;

  // Store lanes for the lower and upper word plus lane-rotated data that
  // serves both halves of a split access.
  typedef struct packed {
    logic [3:0]  mask_lo;
    logic [3:0]  mask_hi;
    logic [31:0] data;
  } store_fmt_t;

  function automatic size_e f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input size_e sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Unsigned loads have no store counterpart.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store);
    case (f3)
      F3_LB, F3_LH, F3_LW: return 1'b0;
      F3_LBU, F3_LHU:      return is_store;
      default:             return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] lane_expand(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

endpackage

// File: rtl/data_memory_sized_if.sv
// MEM-stage data memory bus.
//   master: address, writeData, memRead, memWrite, funct3 -> ; <- memData, stall, access_err
//   slave : the mirror image, used by data_memory_sized.
interface data_memory_sized_if;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  funct3;
  logic [31:0] memData;
  logic        stall;
  logic        access_err;

  modport master (
    output address, writeData, memRead, memWrite, funct3,
    input  memData, stall, access_err
  );

  modport slave (
    input  address, writeData, memRead, memWrite, funct3,
    output memData, stall, access_err
  );
endinterface

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatter for the data memory.
//   offset, size      : byte offset in the word and access size
//   funct3            : load extension select
//   store_data        : raw store operand
//   lo_word, hi_word  : lower word and following word (hi only used when crossing)
//   store_c           : lane masks for both words and lane-rotated store data
//   load_c            : extracted and extended load result
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  output store_fmt_t  store_c,
  output logic [31:0] load_c
);

  logic [2:0]  end_lane;
  logic [31:0] raw;
  logic        unused_hi;

  // One past the last byte, counted from lane 0 of the lower word.
  assign end_lane  = {1'b0, offset} + size_bytes(size);
  // The top byte of the following word is never reached by a 4-byte access.
  assign unused_hi = ^hi_word[31:24];

  // Lane masks and rotated store data; rotation puts each byte in its lane
  // for both words at once.
  always_comb begin
    store_c = '0;
    for (int l = 0; l < 4; l++) begin
      store_c.mask_lo[l] = (3'(l) >= {1'b0, offset}) && (3'(l) < end_lane);
      store_c.mask_hi[l] = 3'(l + 4) < end_lane;
    end
    case (offset)
      2'd0:    store_c.data = store_data;
      2'd1:    store_c.data = {store_data[23:0], store_data[31:24]};
      2'd2:    store_c.data = {store_data[15:0], store_data[31:16]};
      default: store_c.data = {store_data[7:0],  store_data[31:8]};
    endcase
  end

  // Byte extraction across the word pair, then sign/zero extension.
  always_comb begin
    raw = '0;
    case (offset)
      2'd0:    raw = lo_word;
      2'd1:    raw = {hi_word[7:0],  lo_word[31:8]};
      2'd2:    raw = {hi_word[15:0], lo_word[31:16]};
      default: raw = {hi_word[23:0], lo_word[31:24]};
    endcase
    case (funct3)
      F3_LB:   load_c = {{24{raw[7]}},  raw[7:0]};
      F3_LH:   load_c = {{16{raw[15]}}, raw[15:0]};
      F3_LW:   load_c = raw;
      F3_LBU:  load_c = {24'h0, raw[7:0]};
      F3_LHU:  load_c = {16'h0, raw[15:0]};
      default: load_c = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressable MEM-stage data memory with byte/half/word loads and stores.
// Word-crossing accesses run as a two-cycle split when MISALIGN_SPLIT_EN is
// defined; otherwise they are suppressed and flagged on access_err.
//   clk, reset : clock, synchronous active-high reset (also zeroes storage)
//   bus        : data_memory_sized_if.slave (address/writeData/memRead/
//                memWrite/funct3 in; memData/stall/access_err out, combinational)
module data_memory_sized
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_BYTES)
) (
  input  logic            clk,
  input  logic            reset,
  data_memory_sized_if.slave bus
);

  localparam int unsigned NWORDS = DEPTH_BYTES / 4;
  localparam int unsigned IW     = AW - 2;

  logic [31:0]   mem [NWORDS];
  logic [IW-1:0] idx;
  logic [IW-1:0] acc_idx;
  logic [1:0]    offset;
  logic          req;
  logic          is_store;
  logic          is_load;
  logic          illegal;
  logic          crossing;
  size_e         size;
  store_fmt_t    st;
  logic [31:0]   rd_word;
  logic [31:0]   lo_word;
  logic [31:0]   hi_word;
  logic [31:0]   ld_data;
  logic [3:0]    wr_mask;
  logic [31:0]   mem_data_c;
  logic          stall_c;
  logic          err_c;
  logic          unused_addr;

  assign offset      = bus.address[1:0];
  assign idx         = bus.address[AW-1:2];
  assign unused_addr = ^bus.address[31:AW];
  assign req         = bus.memRead | bus.memWrite;
  assign is_store    = bus.memWrite;
  assign is_load     = bus.memRead & ~bus.memWrite;
  assign illegal     = f3_illegal(bus.funct3, bus.memWrite);
  assign size        = f3_size(bus.funct3);
  assign crossing    = |st.mask_hi;
  assign rd_word     = mem[acc_idx];

  dmem_lane_fmt u_fmt (
    .offset     (offset),
    .size       (size),
    .funct3     (bus.funct3),
    .store_data (bus.writeData),
    .lo_word    (lo_word),
    .hi_word    (hi_word),
    .store_c    (st),
    .load_c     (ld_data)
  );

`ifdef MISALIGN_SPLIT_EN
  state_e      state;
  logic [31:0] hold_lo;
  logic        in_second;
  logic        start_split;

  assign in_second   = (state == ST_SECOND);
  assign start_split = !in_second && req && !illegal && crossing;
  // Second half addresses the following word; the last word wraps to 0.
  assign acc_idx     = in_second ? idx + IW'(1) : idx;
  assign lo_word     = in_second ? hold_lo : rd_word;
  assign hi_word     = in_second ? rd_word : '0;

  // Split FSM and captured lower bytes of a crossing load.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      hold_lo <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_split) begin
            state <= ST_SECOND;
            if (is_load) hold_lo <= rd_word & lane_expand(st.mask_lo);
          end
        end
        ST_SECOND: state <= ST_IDLE;
      endcase
    end
  end

  // Write lanes and output selection for the split-capable build.
  always_comb begin
    wr_mask    = '0;
    mem_data_c = '0;
    stall_c    = start_split;
    err_c      = req && illegal;
    if (req && !illegal && is_store) wr_mask = in_second ? st.mask_hi : st.mask_lo;
    if (is_load && !illegal && (!crossing || in_second)) mem_data_c = ld_data;
  end
`else
  assign acc_idx = idx;
  assign lo_word = rd_word;
  assign hi_word = '0;

  // Crossing accesses are suppressed and reported instead of split.
  always_comb begin
    wr_mask    = '0;
    mem_data_c = '0;
    stall_c    = 1'b0;
    err_c      = req && (illegal || crossing);
    if (req && !illegal && is_store && !crossing) wr_mask = st.mask_lo;
    if (is_load && !illegal && !crossing) mem_data_c = ld_data;
  end
`endif

  // Storage: one word port per cycle, byte-lane writes, cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NWORDS); i++) mem[i] <= '0;
    end else begin
      for (int l = 0; l < 4; l++) begin
        if (wr_mask[l]) mem[acc_idx][8*l +: 8] <= st.data[8*l +: 8];
      end
    end
  end

  assign bus.memData    = mem_data_c;
  assign bus.stall      = stall_c;
  assign bus.access_err = err_c;

endmodule

// File: tb/tb_data_memory_sized.sv
// Self-checking bench for data_memory_sized: byte-array reference model,
// per-cycle output comparison, directed literal checks and random traffic.
module tb_data_memory_sized;

  localparam int unsigned D = 1024;
`ifdef MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   chk_en   = 1'b0;

  data_memory_sized_if bus ();

  data_memory_sized #(.DEPTH_BYTES(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] mm [D];
  bit         m_second = 1'b0;

  function automatic int unsigned model_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit model_illegal(input logic [2:0] f3, input logic wr);
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
           (wr && ((f3 == 3'd4) || (f3 == 3'd5)));
  endfunction

  function automatic bit model_crosses(input logic [31:0] a, input logic [2:0] f3);
    return (int'(a % 4) + int'(model_bytes(f3))) > 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
    int unsigned base;
    logic [31:0] v;
    base = a % D;
    v    = '0;
    for (int unsigned i = 0; i < model_bytes(f3); i++)
      v = v | (32'(mm[(base + i) % D]) << (8 * i));
    case (f3)
      3'b000:  v = {{24{v[7]}}, v[7:0]};
      3'b001:  v = {{16{v[15]}}, v[15:0]};
      default: ;
    endcase
    return v;
  endfunction

  function automatic void model_expect(output logic [31:0] md, output logic st, output logic er);
    logic rq, ill, cr;
    rq  = bus.memRead || bus.memWrite;
    ill = model_illegal(bus.funct3, bus.memWrite);
    cr  = model_crosses(bus.address, bus.funct3);
    md  = '0;
    er  = rq && (ill || (!SPLIT && cr));
    st  = SPLIT && rq && !ill && cr && !m_second;
    if (rq && !bus.memWrite && !ill && (!cr || (SPLIT && m_second)))
      md = model_load(bus.address, bus.funct3);
  endfunction

  // Model state update at each rising edge.
  always @(posedge clk) begin
    int unsigned base, off;
    bit cr;
    base = bus.address % D;
    off  = bus.address % 4;
    cr   = model_crosses(bus.address, bus.funct3);
    if (reset) begin
      for (int i = 0; i < int'(D); i++) mm[i] <= 8'h00;
      m_second <= 1'b0;
    end else if ((bus.memRead || bus.memWrite) && !model_illegal(bus.funct3, bus.memWrite)) begin
      if (!cr || SPLIT) begin
        if (bus.memWrite) begin
          for (int unsigned i = 0; i < model_bytes(bus.funct3); i++) begin
            if (!cr || (m_second == ((off + i) >= 4)))
              mm[(base + i) % D] <= bus.writeData[8*i +: 8];
          end
        end
        if (cr) m_second <= !m_second;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [31:0] emd;
    logic est, eer;
    if (chk_en) begin
      model_expect(emd, est, eer);
      chk("memData", bus.memData, emd);
      chk("stall", 32'(bus.stall), 32'(est));
      chk("access_err", 32'(bus.access_err), 32'(eer));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic rst, input logic [31:0] a, input logic [31:0] wd,
                      input logic rd, input logic wr, input logic [2:0] f3);
    @(posedge clk);
    #1;
    reset         = rst;
    bus.address   = a;
    bus.writeData = wd;
    bus.memRead   = rd;
    bus.memWrite  = wr;
    bus.funct3    = f3;
    @(negedge clk);
  endtask

  task automatic ld(input logic [31:0] a, input logic [2:0] f3);
    step(1'b0, a, 32'h0, 1'b1, 1'b0, f3);
  endtask

  task automatic sto(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    step(1'b0, a, d, 1'b0, 1'b1, f3);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b010);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.address = '0; bus.writeData = '0; bus.memRead = 1'b0;
    bus.memWrite = 1'b0; bus.funct3 = 3'b010;
    step(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 3'b010);
    step(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 3'b010);
    chk_en = 1'b1;

    // Reset state and a first load.
    ld(32'h10, 3'b010);
    chk("lw_after_reset", bus.memData, 32'h0);
    chk("stall_after_reset", 32'(bus.stall), 32'h0);
    chk("err_after_reset", 32'(bus.access_err), 32'h0);

    // Extension variants.
    sto(32'h20, 32'h8899AABB, 3'b010);
    ld(32'h23, 3'b000); chk("lb_23", bus.memData, 32'hFFFFFF88);
    ld(32'h23, 3'b100); chk("lbu_23", bus.memData, 32'h00000088);
    ld(32'h22, 3'b001); chk("lh_22", bus.memData, 32'hFFFF8899);
    ld(32'h22, 3'b101); chk("lhu_22", bus.memData, 32'h00008899);
    ld(32'h21, 3'b001); chk("lh_21_nocross", bus.memData, 32'hFFFF99AA);

    // Crossing word store and loads.
    sto(32'h41, 32'hDEADBEEF, 3'b010);
    if (SPLIT) begin
      chk("sw41_stall1", 32'(bus.stall), 32'h1);
      sto(32'h41, 32'hDEADBEEF, 3'b010);
      chk("sw41_stall2", 32'(bus.stall), 32'h0);
    end else begin
      chk("sw41_err", 32'(bus.access_err), 32'h1);
      chk("sw41_nostall", 32'(bus.stall), 32'h0);
    end
    ld(32'h40, 3'b010); chk("lw_40", bus.memData, SPLIT ? 32'hADBEEF00 : 32'h0);
    ld(32'h44, 3'b010); chk("lw_44", bus.memData, SPLIT ? 32'h000000DE : 32'h0);
    ld(32'h41, 3'b010);
    if (SPLIT) begin
      chk("lw41_stall", 32'(bus.stall), 32'h1);
      chk("lw41_data1", bus.memData, 32'h0);
      ld(32'h41, 3'b010);
      chk("lw41_data2", bus.memData, 32'hDEADBEEF);
    end else begin
      chk("lw41_err", 32'(bus.access_err), 32'h1);
      chk("lw41_data", bus.memData, 32'h0);
      chk("lw41_nostall", 32'(bus.stall), 32'h0);
    end

    // Halfword wrapping from the last byte to byte 0.
    sto(32'(D - 1), 32'h00001234, 3'b001);
    if (SPLIT) sto(32'(D - 1), 32'h00001234, 3'b001);
    ld(32'(D - 1), 3'b100); chk("lbu_top", bus.memData, SPLIT ? 32'h34 : 32'h0);
    ld(32'h0, 3'b100);      chk("lbu_0", bus.memData, SPLIT ? 32'h12 : 32'h0);
    ld(32'(D - 1), 3'b101);
    if (SPLIT) ld(32'(D - 1), 3'b101);
    chk("lhu_top", bus.memData, SPLIT ? 32'h00001234 : 32'h0);

    // Illegal funct3 leaves memory unchanged.
    sto(32'h80, 32'h11223344, 3'b010);
    sto(32'h80, 32'hFFFFFFFF, 3'b011);
    chk("f3_011_err", 32'(bus.access_err), 32'h1);
    sto(32'h80, 32'hFFFFFFFF, 3'b100);
    chk("sbu_err", 32'(bus.access_err), 32'h1);
    ld(32'h80, 3'b010); chk("lw_80_kept", bus.memData, 32'h11223344);
    ld(32'h80, 3'b111); chk("f3_111_data", bus.memData, 32'h0);

    // Reset asserted during the second half of a crossing store.
    sto(32'h49, 32'hCAFEF00D, 3'b010);
    step(1'b1, 32'h49, 32'hCAFEF00D, 1'b0, 1'b1, 3'b010);
    idle();
    chk("stall_post_reset", 32'(bus.stall), 32'h0);
    ld(32'h48, 3'b010); chk("lw_48_cleared", bus.memData, 32'h0);
    ld(32'h4C, 3'b010); chk("lw_4c_cleared", bus.memData, 32'h0);
    ld(32'h20, 3'b010); chk("lw_20_cleared", bus.memData, 32'h0);

    // Random traffic against the model.
    for (int k = 0; k < 800; k++) begin
      logic [31:0] a, wd;
      logic rd, wr;
      logic [2:0] f3;
      int unsigned lo;
      a  = $urandom;
      lo = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 63) : (D - 64 + $urandom_range(0, 63));
      a  = (a & ~32'(D - 1)) | 32'(lo);
      wd = $urandom;
      if ($urandom_range(0, 5) == 0) f3 = 3'($urandom_range(0, 7));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end
      case ($urandom_range(0, 5))
        0:       begin rd = 1'b0; wr = 1'b0; end
        1, 2:    begin rd = 1'b0; wr = 1'b1; end
        3:       begin rd = 1'b1; wr = 1'b1; end
        default: begin rd = 1'b1; wr = 1'b0; end
      endcase
      if ($urandom_range(0, 80) == 0) begin
        step(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 3'b010);
      end else begin
        step(1'b0, a, wd, rd, wr, f3);
        if (SPLIT && (rd || wr) && !model_illegal(f3, wr) && model_crosses(a, f3))
          step(1'b0, a, wd, rd, wr, f3);
      end
    end

    idle();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
